// File: rtl/vec_cache_edge_resp_collector.sv
// vec_cache_edge_resp_collector: terminates the 8-channel data mesh at one edge
// of a vec_cache block row. Buffers incoming beats in per-channel FIFOs, returns
// one credit per freed entry, and drains the FIFOs round-robin onto a single
// valid/ready response stream.
// Optional feature: define VEC_CACHE_EDGE_DIR_CHECK_EN to drop (and flag) beats
// whose txn direction does not match EDGE_DIR.

package vec_cache_edge_resp_collector_pkg;

  localparam logic [1:0] DIR_WEST  = 2'd0;
  localparam logic [1:0] DIR_EAST  = 2'd1;
  localparam logic [1:0] DIR_SOUTH = 2'd2;
  localparam logic [1:0] DIR_NORTH = 2'd3;

  typedef struct packed {
    logic [1:0] direction_id;
    logic [5:0] seq_id;
  } txn_id_t;

  typedef struct packed {
    txn_id_t    txn_id;
    logic [7:0] addr;
  } cmd_pld_t;

  typedef struct packed {
    cmd_pld_t    cmd_pld;
    logic [31:0] data;
  } data_pld_t;

endpackage

module vec_cache_edge_resp_collector
  import vec_cache_edge_resp_collector_pkg::*;
#(
  parameter int unsigned CH_NUM     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EDGE_DIR   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CH_NUM-1:0]           mesh_vld,
  input  data_pld_t [CH_NUM-1:0]      mesh_pld,
  output logic [CH_NUM-1:0]           credit_rtn,
  output logic                        resp_vld,
  input  logic                        resp_rdy,
  output data_pld_t                   resp_pld,
  output logic [$clog2(CH_NUM)-1:0]   resp_ch,
  output logic [CH_NUM-1:0]           err_ovf,
  output logic                        err_dir
);

  localparam int unsigned CH_W = $clog2(CH_NUM);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PW   = AW + 1;

  // Elaboration-time parameter sanity
  if (CH_NUM < 2) begin : g_bad_ch
    $error("CH_NUM must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (EDGE_DIR > 3) begin : g_bad_dir
    $error("EDGE_DIR must fit in 2 bits");
  end

  data_pld_t         mem_q    [CH_NUM][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q [CH_NUM];
  logic [PW-1:0]     rd_ptr_q [CH_NUM];
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   lock_gnt_q;
  logic              lock_q;

  logic [CH_NUM-1:0] empty_c;
  logic [CH_NUM-1:0] full_c;
  logic [CH_NUM-1:0] push_c;
  logic [CH_NUM-1:0] pop_c;
  logic [CH_NUM-1:0] ovf_c;
  logic [CH_NUM-1:0] dir_bad_c;
  logic [CH_W-1:0]   rr_gnt_c;
  logic [CH_W-1:0]   gnt_c;
  logic              rr_found_c;
  logic              hs_c;

  // FIFO occupancy status from wrap-bit pointers
  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_c[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                   (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

`ifdef VEC_CACHE_EDGE_DIR_CHECK_EN
  // Flag valid beats that were steered to the wrong edge
  always_comb begin
    dir_bad_c = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      dir_bad_c[i] = mesh_vld[i] &&
                     (mesh_pld[i].cmd_pld.txn_id.direction_id != 2'(EDGE_DIR));
    end
  end

  // Sticky direction-mismatch flag
  always_ff @(posedge clk) begin
    if (rst) err_dir <= 1'b0;
    else     err_dir <= err_dir | (|dir_bad_c);
  end
`else
  assign dir_bad_c = '0;
  assign err_dir   = 1'b0;
`endif

  // Round-robin search over non-empty FIFOs starting at the pointer
  always_comb begin
    rr_gnt_c   = '0;
    rr_found_c = 1'b0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % CH_NUM;
      if (!rr_found_c && !empty_c[idx]) begin
        rr_found_c = 1'b1;
        rr_gnt_c   = CH_W'(idx);
      end
    end
  end

  // A stalled grant stays locked so the presented beat cannot change
  assign gnt_c    = lock_q ? lock_gnt_q : rr_gnt_c;
  assign resp_vld = rr_found_c;
  assign resp_ch  = resp_vld ? gnt_c : '0;
  assign resp_pld = resp_vld ? mem_q[gnt_c][rd_ptr_q[gnt_c][AW-1:0]] : '0;
  assign hs_c     = resp_vld && resp_rdy;
  assign pop_c    = hs_c ? (CH_NUM'(1) << gnt_c) : '0;

  // Push qualification; a full FIFO only accepts when it pops the same cycle
  always_comb begin
    push_c = '0;
    ovf_c  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      push_c[i] = mesh_vld[i] && !dir_bad_c[i] && (!full_c[i] || pop_c[i]);
      ovf_c[i]  = mesh_vld[i] && !dir_bad_c[i] && full_c[i] && !pop_c[i];
    end
  end

  // FIFO storage (contents are don't-care until written)
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (push_c[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= mesh_pld[i];
    end
  end

  // Pointers, arbiter state, credits and overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_gnt_q <= '0;
      credit_rtn <= '0;
      err_ovf    <= '0;
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (push_c[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop_c[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
      end
      if (hs_c) rr_ptr_q <= (gnt_c == CH_W'(CH_NUM - 1)) ? '0 : gnt_c + CH_W'(1);
      lock_q     <= resp_vld && !resp_rdy;
      lock_gnt_q <= gnt_c;
      credit_rtn <= pop_c | dir_bad_c;
      err_ovf    <= err_ovf | ovf_c;
    end
  end

endmodule

// File: tb/tb_vec_cache_edge_resp_collector.sv
// Scoreboard bench for vec_cache_edge_resp_collector: stimulus pushes expected
// beats in hand-derived arbitration order; a negedge monitor checks responses,
// credit pulses and stall stability.
module tb_vec_cache_edge_resp_collector;
  import vec_cache_edge_resp_collector_pkg::*;

  localparam int unsigned CH_NUM = 8;

  typedef struct {
    int        ch;
    data_pld_t pld;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CH_NUM-1:0]     mesh_vld;
  data_pld_t [CH_NUM-1:0] mesh_pld;
  logic [CH_NUM-1:0]     credit_rtn;
  logic                  resp_vld;
  logic                  resp_rdy;
  data_pld_t             resp_pld;
  logic [2:0]            resp_ch;
  logic [CH_NUM-1:0]     err_ovf;
  logic                  err_dir;

  int tests_run = 0;
  int fails = 0;

  exp_t             exp_q [$];
  exp_t             e;
  logic [7:0]       exp_credit = '0;
  logic [7:0]       extra_credit = '0;
  logic [7:0]       nxt;
  logic             mon_en = 1'b0;
  logic             prev_stall = 1'b0;
  logic [2:0]       prev_ch = '0;
  data_pld_t        prev_pld = '0;

  vec_cache_edge_resp_collector #(
    .CH_NUM(CH_NUM), .FIFO_DEPTH(4), .EDGE_DIR(0)
  ) dut (
    .clk(clk), .rst(rst), .mesh_vld(mesh_vld), .mesh_pld(mesh_pld),
    .credit_rtn(credit_rtn), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
    .resp_pld(resp_pld), .resp_ch(resp_ch), .err_ovf(err_ovf), .err_dir(err_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic data_pld_t mk_pld(input int ch, input int seq, input logic [1:0] dir);
    data_pld_t p;
    p.data                       = {8'(ch), 8'(seq), 16'hC0DE};
    p.cmd_pld.addr               = 8'(ch * 16 + seq);
    p.cmd_pld.txn_id.direction_id = dir;
    p.cmd_pld.txn_id.seq_id      = 6'(seq);
    return p;
  endfunction

  // Advance to just after the next rising edge and retire one-cycle inputs
  task automatic tick();
    @(posedge clk);
    #1;
    mesh_vld     = '0;
    extra_credit = '0;
  endtask

  task automatic beat(input int ch, input int seq, input logic [1:0] dir, input bit expect_out);
    exp_t x;
    mesh_vld[ch] = 1'b1;
    mesh_pld[ch] = mk_pld(ch, seq, dir);
    if (expect_out) begin
      x.ch  = ch;
      x.pld = mesh_pld[ch];
      exp_q.push_back(x);
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: response scoreboard, registered credit model, stall stability
  always @(negedge clk) begin
    if (mon_en) begin
      chk("credit_rtn", 64'(credit_rtn), 64'(exp_credit));
      if (prev_stall) begin
        chk("stall_vld", 64'(resp_vld), 64'(1));
        chk("stall_ch", 64'(resp_ch), 64'(prev_ch));
        chk("stall_pld", 64'(resp_pld), 64'(prev_pld));
      end
      nxt = '0;
      if (resp_vld && resp_rdy && !rst) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_resp: got ch %0d, none expected at %0t", resp_ch, $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_ch", 64'(resp_ch), 64'(e.ch));
          chk("resp_pld", 64'(resp_pld), 64'(e.pld));
          nxt = 8'(1) << e.ch;
        end
      end
      exp_credit = rst ? 8'h00 : (nxt | extra_credit);
      prev_stall = resp_vld && !resp_rdy && !rst;
      prev_ch    = resp_ch;
      prev_pld   = resp_pld;
    end
  end

  initial begin
    rst      = 1'b1;
    mesh_vld = '0;
    mesh_pld = '0;
    resp_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_resp_vld", 64'(resp_vld), 64'(0));
    chk("rst_resp_ch", 64'(resp_ch), 64'(0));
    chk("rst_resp_pld", 64'(resp_pld), 64'(0));
    chk("rst_err_ovf", 64'(err_ovf), 64'(0));
    chk("rst_err_dir", 64'(err_dir), 64'(0));
    tick();

    // 1: single beat on ch3, one-cycle latency, credit 8'h08 one cycle later
    do_reset();
    resp_rdy = 1'b1;
    beat(3, 1, DIR_WEST, 1'b1);
    tick();
    @(negedge clk);
    chk("t1_vld", 64'(resp_vld), 64'(1));
    chk("t1_ch", 64'(resp_ch), 64'(3));
    repeat (3) tick();

    // 2: all channels at once drain 0..7 back to back
    do_reset();
    resp_rdy = 1'b1;
    for (int c = 0; c < 8; c++) beat(c, 2, DIR_WEST, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_vld", 64'(resp_vld), 64'(1));
      chk("t2_ch", 64'(resp_ch), 64'(k));
    end
    @(negedge clk);
    chk("t2_idle", 64'(resp_vld), 64'(0));
    tick();

    // 3: five beats into ch0 with no drain -> fifth dropped, overflow flagged
    do_reset();
    resp_rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      beat(0, s, DIR_WEST, s < 4);
      tick();
    end
    @(negedge clk);
    chk("t3_ovf", 64'(err_ovf), 64'(8'h01));
    tick();
    resp_rdy = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("t3_drained", 64'(resp_vld), 64'(0));
    chk("t3_ovf_sticky", 64'(err_ovf), 64'(8'h01));
    tick();

    // 4: stall with ch1, ch2 pending (pointer now 1) -> ch1 held for 6 cycles
    resp_rdy = 1'b0;
    beat(1, 3, DIR_WEST, 1'b1);
    beat(2, 3, DIR_WEST, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_ch_held", 64'(resp_ch), 64'(1));
    end
    tick();
    resp_rdy = 1'b1;
    repeat (3) tick();

    // 4b: pointer now 3; ch5 granted and stalled, then ch3 arrives -> grant stays 5
    resp_rdy = 1'b0;
    beat(5, 4, DIR_WEST, 1'b1);
    tick();
    beat(3, 4, DIR_WEST, 1'b1);
    tick();
    @(negedge clk);
    chk("t4b_lock_ch", 64'(resp_ch), 64'(5));
    tick();
    resp_rdy = 1'b1;
    repeat (3) tick();

    // 5: reset with three beats buffered discards them and clears flags
    resp_rdy = 1'b0;
    beat(0, 5, DIR_WEST, 1'b0);
    beat(1, 5, DIR_WEST, 1'b0);
    beat(2, 5, DIR_WEST, 1'b0);
    tick();
    @(negedge clk);
    chk("t5_pre_ovf", 64'(err_ovf), 64'(8'h01));
    chk("t5_pre_vld", 64'(resp_vld), 64'(1));
    tick();
    resp_rdy = 1'b1;
    do_reset();
    @(negedge clk);
    chk("t5_vld", 64'(resp_vld), 64'(0));
    chk("t5_ovf", 64'(err_ovf), 64'(0));
    chk("t5_dir", 64'(err_dir), 64'(0));
    chk("t5_ch", 64'(resp_ch), 64'(0));
    chk("t5_pld", 64'(resp_pld), 64'(0));
    repeat (3) tick();

    // 6: NORTH beat on ch4 at a WEST edge next to a WEST beat on ch5
    do_reset();
    resp_rdy = 1'b1;
`ifdef VEC_CACHE_EDGE_DIR_CHECK_EN
    beat(4, 6, DIR_NORTH, 1'b0);
    extra_credit = 8'h10;
`else
    beat(4, 6, DIR_NORTH, 1'b1);
`endif
    beat(5, 6, DIR_WEST, 1'b1);
    tick();
    @(negedge clk);
`ifdef VEC_CACHE_EDGE_DIR_CHECK_EN
    chk("t6_err_dir", 64'(err_dir), 64'(1));
    chk("t6_first_ch", 64'(resp_ch), 64'(5));
`else
    chk("t6_err_dir", 64'(err_dir), 64'(0));
    chk("t6_first_ch", 64'(resp_ch), 64'(4));
`endif
    repeat (4) tick();
    @(negedge clk);
    chk("t6_idle", 64'(resp_vld), 64'(0));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
